// File: rtl/scan_pos_generator.sv
`default_nettype none
// ============================================================================
// Module   : scan_pos_generator
// Purpose  : Sequential HEVC scan-position generator for the RDOQ datapath.
//            Walks a TU as 4x4 sub-blocks in diagonal, horizontal or vertical
//            order, forward or in reverse from a chosen sub-block. One
//            position is emitted per valid/ready beat.
// Revision : 1.0 - initial release
// ============================================================================
module scan_pos_generator #(
  parameter int MAX_LOG2_TU = 5,
  localparam int CW = MAX_LOG2_TU,
  localparam int IW = 2 * MAX_LOG2_TU,
  localparam int SW = 2 * (MAX_LOG2_TU - 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [2:0]    log2_tu,
  input  logic [1:0]    scan_type,
  input  logic          reverse,
  input  logic [SW-1:0] start_sb,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_x,
  output logic [CW-1:0] out_y,
  output logic [IW-1:0] out_raster,
  output logic [IW-1:0] out_scan_idx,
  output logic [SW-1:0] out_sb_idx,
  output logic          out_sb_first,
  output logic          out_sb_last,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] THREE_C = CW'(3);
  localparam logic [CW:0]   ONE_D   = (CW + 1)'(1);
  localparam logic [SW-1:0] ONE_S   = SW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t        state;
  logic [2:0]    cfg_lg;
  logic [1:0]    cfg_st;
  logic          cfg_rev;
  logic [SW-1:0] cfg_target;
  logic [SW-1:0] cfg_last_sb;

  // Walker state: sub-block coordinates/index and coefficient coordinates/pos.
  // Coordinates are kept at full CW width so one stepping function serves both.
  logic [CW-1:0] sbx, sby, cx, cy;
  logic [SW-1:0] sb_idx;
  logic [3:0]    pos;

  // One step of a walker over a square grid of width 2^lw, either direction.
  // Returns {next_y, next_x}.
  function automatic logic [2*CW-1:0] step_pos(
    input logic [CW-1:0] x,
    input logic [CW-1:0] y,
    input logic [2:0]    lw,
    input logic [1:0]    st,
    input logic          rev
  );
    logic [CW-1:0] wm, nx, ny;
    logic [CW:0]   d;
    wm = ~({CW{1'b1}} << lw);
    nx = x;
    ny = y;
    d  = '0;
    case (st)
      2'd1: begin
        if (!rev) begin
          if (x == wm) begin nx = '0; ny = y + ONE_C; end
          else nx = x + ONE_C;
        end else begin
          if (x == '0) begin nx = wm; ny = y - ONE_C; end
          else nx = x - ONE_C;
        end
      end
      2'd2: begin
        if (!rev) begin
          if (y == wm) begin ny = '0; nx = x + ONE_C; end
          else ny = y + ONE_C;
        end else begin
          if (y == '0) begin ny = wm; nx = x - ONE_C; end
          else ny = y - ONE_C;
        end
      end
      default: begin
        if (!rev) begin
          // End of an anti-diagonal: jump to the bottom-left of the next one.
          if (y == '0 || x == wm) begin
            d  = {1'b0, x} + {1'b0, y} + ONE_D;
            ny = (d > {1'b0, wm}) ? wm : d[CW-1:0];
            nx = d[CW-1:0] - ny;
          end else begin
            nx = x + ONE_C;
            ny = y - ONE_C;
          end
        end else begin
          // Start of an anti-diagonal: jump to the top-right of the previous one.
          if (x == '0 || y == wm) begin
            d  = {1'b0, x} + {1'b0, y} - ONE_D;
            nx = (d > {1'b0, wm}) ? wm : d[CW-1:0];
            ny = d[CW-1:0] - nx;
          end else begin
            nx = x - ONE_C;
            ny = y + ONE_C;
          end
        end
      end
    endcase
    return {ny, nx};
  endfunction

  logic [2*CW-1:0] sb_seek_nxt, sb_run_nxt, cf_nxt;
  logic [SW:0]     req_nsb;
  logic            req_ok;
  logic            sb_end, walk_last;

  // Start-request legality and size of the requested sub-block grid.
  always_comb begin
    req_nsb = (SW + 1)'(1) << {log2_tu - 3'd2, 1'b0};
    req_ok  = 1'b1;
    if (log2_tu < 3'd2 || log2_tu > 3'(MAX_LOG2_TU)) req_ok = 1'b0;
    if (scan_type == 2'd3) req_ok = 1'b0;
    if (scan_type != 2'd0 && log2_tu > 3'd3) req_ok = 1'b0;
    if (reverse && ({1'b0, start_sb} >= req_nsb)) req_ok = 1'b0;
  end

  assign sb_seek_nxt = step_pos(sbx, sby, cfg_lg - 3'd2, cfg_st, 1'b0);
  assign sb_run_nxt  = step_pos(sbx, sby, cfg_lg - 3'd2, cfg_st, cfg_rev);
  assign cf_nxt      = step_pos(cx, cy, 3'd2, cfg_st, cfg_rev);

  assign sb_end    = cfg_rev ? (pos == 4'd0) : (pos == 4'd15);
  assign walk_last = sb_end && (cfg_rev ? (sb_idx == '0) : (sb_idx == cfg_last_sb));

  // Control FSM and walker state; abort and the last handshake return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cfg_lg      <= '0;
      cfg_st      <= '0;
      cfg_rev     <= 1'b0;
      cfg_target  <= '0;
      cfg_last_sb <= '0;
      sbx         <= '0;
      sby         <= '0;
      sb_idx      <= '0;
      cx          <= '0;
      cy          <= '0;
      pos         <= '0;
      out_valid   <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            if (req_ok) begin
              cfg_lg      <= log2_tu;
              cfg_st      <= scan_type;
              cfg_rev     <= reverse;
              cfg_target  <= reverse ? start_sb : '0;
              cfg_last_sb <= SW'(req_nsb - (SW + 1)'(1));
              sbx         <= '0;
              sby         <= '0;
              sb_idx      <= '0;
              cx          <= reverse ? THREE_C : '0;
              cy          <= reverse ? THREE_C : '0;
              pos         <= reverse ? 4'd15 : 4'd0;
              state       <= (reverse && start_sb != '0) ? SEEK : RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SEEK: begin
          if (abort) begin
            state <= IDLE;
          end else if (sb_idx == cfg_target) begin
            state     <= RUN;
            out_valid <= 1'b1;
          end else begin
            sbx    <= sb_seek_nxt[CW-1:0];
            sby    <= sb_seek_nxt[2*CW-1:CW];
            sb_idx <= sb_idx + ONE_S;
          end
        end
        RUN: begin
          if (abort) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end else if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            if (walk_last) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else if (sb_end) begin
              sbx    <= sb_run_nxt[CW-1:0];
              sby    <= sb_run_nxt[2*CW-1:CW];
              sb_idx <= cfg_rev ? (sb_idx - ONE_S) : (sb_idx + ONE_S);
              cx     <= cfg_rev ? THREE_C : '0;
              cy     <= cfg_rev ? THREE_C : '0;
              pos    <= cfg_rev ? 4'd15 : 4'd0;
            end else begin
              cx  <= cf_nxt[CW-1:0];
              cy  <= cf_nxt[2*CW-1:CW];
              pos <= cfg_rev ? (pos - 4'd1) : (pos + 4'd1);
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_x        = (sbx << 2) | cx;
  assign out_y        = (sby << 2) | cy;
  assign out_raster   = (IW'(out_y) << cfg_lg) | IW'(out_x);
  assign out_scan_idx = {sb_idx, pos};
  assign out_sb_idx   = sb_idx;
  assign out_sb_first = out_valid && (cfg_rev ? (pos == 4'd15) : (pos == 4'd0));
  assign out_sb_last  = out_valid && sb_end;
  assign out_last     = out_valid && walk_last;
  assign busy         = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_scan_pos_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_pos_generator
// Purpose  : Directed self-checking bench for scan_pos_generator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_pos_generator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       reverse = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] log2_tu = 3'd0;
  logic [1:0] scan_type = 2'd0;
  logic [5:0] start_sb = 6'd0;

  logic       out_valid, out_sb_first, out_sb_last, out_last, busy, done, err;
  logic [4:0] out_x, out_y;
  logic [9:0] out_raster, out_scan_idx;
  logic [5:0] out_sb_idx;

  int n_assert = 0;
  int n_fail = 0;

  int diag4[16] = '{0, 4, 1, 8, 5, 2, 12, 9, 6, 3, 13, 10, 7, 14, 11, 15};
  int exp_r[1024];

  int got_raster[1024];
  int got_scan[1024];
  int got_x[1024];
  int got_y[1024];
  int got_first[1024];
  int got_sblast[1024];
  int n_beats, first_cyc, bubble_cnt, last_cnt, done_in_walk;

  scan_pos_generator #(.MAX_LOG2_TU(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .log2_tu(log2_tu), .scan_type(scan_type), .reverse(reverse),
    .start_sb(start_sb), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_raster(out_raster),
    .out_scan_idx(out_scan_idx), .out_sb_idx(out_sb_idx),
    .out_sb_first(out_sb_first), .out_sb_last(out_sb_last),
    .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] lg, input logic [1:0] st, input logic rv,
                        input logic [5:0] sb);
    log2_tu = lg; scan_type = st; reverse = rv; start_sb = sb;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Forward diagonal raster order built by enumerating anti-diagonals.
  task automatic build_diag(input int lg);
    int g, k, x, y, cxx, cyy;
    g = 1 << (lg - 2);
    k = 0;
    for (int sd = 0; sd <= 2 * g - 2; sd++)
      for (int sy = g - 1; sy >= 0; sy--) begin
        x = sd - sy;
        if (sy <= sd && x < g)
          for (int cd = 0; cd <= 6; cd++)
            for (int cy2 = 3; cy2 >= 0; cy2--) begin
              cxx = cd - cy2;
              cyy = cy2;
              if (cy2 <= cd && cxx < 4) begin
                y = sy * 4 + cyy;
                exp_r[k] = y * (1 << lg) + x * 4 + cxx;
                k++;
              end
            end
      end
  endtask

  // Collect beats from the cycle after start is sampled until the last handshake.
  task automatic run_walk(input int budget, input bit stall);
    int cyc, forced;
    bit fin, prev_stall;
    logic [63:0] prev_pl, cur_pl;
    n_beats = 0; first_cyc = -1; bubble_cnt = 0; last_cnt = 0; done_in_walk = 0;
    cyc = 0; forced = 0; fin = 0; prev_stall = 0; prev_pl = '0;
    out_ready = 1'b1;
    while (!fin && cyc < budget) begin
      cur_pl = {25'd0, out_x, out_y, out_raster, out_scan_idx, out_sb_idx,
                out_sb_first, out_sb_last, out_last};
      if (done) done_in_walk++;
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      if (!out_valid && first_cyc >= 0) bubble_cnt++;
      if (prev_stall) check("stall_hold", cur_pl, prev_pl);
      if (stall) begin
        if (n_beats == 100 && forced < 5) begin out_ready = 1'b0; forced++; end
        else out_ready = ($urandom_range(0, 3) != 0);
      end
      if (out_valid && out_ready) begin
        if (n_beats < 1024) begin
          got_raster[n_beats] = int'(out_raster);
          got_scan[n_beats]   = int'(out_scan_idx);
          got_x[n_beats]      = int'(out_x);
          got_y[n_beats]      = int'(out_y);
          got_first[n_beats]  = int'(out_sb_first);
          got_sblast[n_beats] = int'(out_sb_last);
        end
        if (out_last) begin last_cnt++; fin = 1; end
        n_beats++;
      end
      prev_stall = out_valid && !out_ready;
      prev_pl = cur_pl;
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    check("walk_finished", 64'(fin), 1);
    check("no_bubbles", 64'(bubble_cnt), 0);
    check("no_early_done", 64'(done_in_walk), 0);
    check("done_pulse", 64'(done), 1);
    check("busy_at_done", 64'(busy), 0);
    check("valid_at_done", 64'(out_valid), 0);
    tick();
    check("done_single", 64'(done), 0);
  endtask

  initial begin
    int hs, seen_done;

    // Reset state
    tick(); tick();
    check("rst_valid", 64'(out_valid), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_err", 64'(err), 0);
    check("rst_payload", {25'd0, out_x, out_y, out_raster, out_scan_idx, out_sb_idx,
                          out_sb_first, out_sb_last, out_last}, 0);
    rst_n = 1'b1;
    tick();

    // Forward 4x4 diagonal
    launch(3'd2, 2'd0, 1'b0, 6'd0);
    run_walk(100, 1'b0);
    check("t1_beats", 64'(n_beats), 16);
    check("t1_latency", 64'(first_cyc), 1);
    check("t1_last_cnt", 64'(last_cnt), 1);
    for (int k = 0; k < 16; k++) check("t1_raster", 64'(got_raster[k]), 64'(diag4[k]));

    // Forward 8x8 vertical
    launch(3'd3, 2'd2, 1'b0, 6'd0);
    run_walk(200, 1'b0);
    check("t2_beats", 64'(n_beats), 64);
    check("t2_raster1", 64'(got_raster[1]), 8);
    check("t2_s16_x", 64'(got_x[16]), 0);
    check("t2_s16_y", 64'(got_y[16]), 4);
    check("t2_s16_raster", 64'(got_raster[16]), 32);
    check("t2_s16_scan", 64'(got_scan[16]), 16);
    check("t2_sb1", 64'({got_x[16] >> 2, got_y[16] >> 2}), 64'({32'd0, 32'd1}));
    check("t2_sb2", 64'({got_x[32] >> 2, got_y[32] >> 2}), 64'({32'd1, 32'd0}));
    check("t2_sb3", 64'({got_x[48] >> 2, got_y[48] >> 2}), 64'({32'd1, 32'd1}));
    check("t2_last_raster", 64'(got_raster[63]), 63);

    // Reverse 16x16 diagonal from sub-block 5
    build_diag(4);
    launch(3'd4, 2'd0, 1'b1, 6'd5);
    run_walk(300, 1'b0);
    check("t3_beats", 64'(n_beats), 96);
    check("t3_latency", 64'(first_cyc), 6);
    check("t3_first_x", 64'(got_x[0]), 11);
    check("t3_first_y", 64'(got_y[0]), 3);
    check("t3_first_raster", 64'(got_raster[0]), 59);
    check("t3_first_scan", 64'(got_scan[0]), 95);
    check("t3_sb_first", 64'(got_first[0]), 1);
    check("t3_sb_last", 64'(got_sblast[15]), 1);
    check("t3_sb_first16", 64'(got_first[16]), 1);
    check("t3_last_raster", 64'(got_raster[95]), 0);
    for (int k = 0; k < 96; k++) begin
      check("t3_raster", 64'(got_raster[k]), 64'(exp_r[95 - k]));
      check("t3_scan", 64'(got_scan[k]), 64'(95 - k));
    end

    // Reverse 32x32 diagonal from sub-block 63 with stalls
    build_diag(5);
    launch(3'd5, 2'd0, 1'b1, 6'd63);
    run_walk(6000, 1'b1);
    check("t4_beats", 64'(n_beats), 1024);
    check("t4_latency", 64'(first_cyc), 64);
    check("t4_first_raster", 64'(got_raster[0]), 1023);
    check("t4_last_cnt", 64'(last_cnt), 1);
    for (int k = 0; k < 1024; k++) check("t4_raster", 64'(got_raster[k]), 64'(exp_r[1023 - k]));

    // Illegal configurations
    launch(3'd4, 2'd1, 1'b0, 6'd0);
    check("t5_err", 64'(err), 1);
    check("t5_valid", 64'(out_valid), 0);
    check("t5_busy", 64'(busy), 0);
    tick();
    check("t5_err_pulse", 64'(err), 0);
    check("t5_valid2", 64'(out_valid), 0);
    check("t5_busy2", 64'(busy), 0);
    launch(3'd2, 2'd0, 1'b1, 6'd1);
    check("t5_sb_range_err", 64'(err), 1);
    check("t5_sb_range_busy", 64'(busy), 0);
    tick();

    // Abort at beat 7
    launch(3'd2, 2'd0, 1'b0, 6'd0);
    out_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid && hs == 6) break;
      if (out_valid && out_ready) hs++;
      tick();
    end
    check("t6_beat7_raster", 64'(out_raster), 12);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_valid", 64'(out_valid), 0);
    check("t6_busy", 64'(busy), 0);
    seen_done = int'(done);
    repeat (4) begin tick(); seen_done += int'(done); end
    check("t6_no_done", 64'(seen_done), 0);
    launch(3'd2, 2'd0, 1'b0, 6'd0);
    run_walk(100, 1'b0);
    check("t6_rerun_beats", 64'(n_beats), 16);
    for (int k = 0; k < 16; k++) check("t6_rerun_raster", 64'(got_raster[k]), 64'(diag4[k]));

    // Asynchronous reset in the middle of SEEK
    launch(3'd5, 2'd0, 1'b1, 6'd40);
    repeat (5) tick();
    check("t7_seek_busy", 64'(busy), 1);
    check("t7_seek_valid", 64'(out_valid), 0);
    #2 rst_n = 1'b0;
    #1;
    check("t7_async_busy", 64'(busy), 0);
    check("t7_async_sbidx", 64'(out_sb_idx), 0);
    tick();
    rst_n = 1'b1;
    seen_done = 0;
    repeat (3) begin tick(); seen_done += int'(done) + int'(out_valid); end
    check("t7_quiet", 64'(seen_done), 0);
    build_diag(3);
    launch(3'd3, 2'd0, 1'b0, 6'd0);
    run_walk(200, 1'b0);
    check("t7_rerun_beats", 64'(n_beats), 64);
    for (int k = 0; k < 64; k++) check("t7_rerun_raster", 64'(got_raster[k]), 64'(exp_r[k]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
